sys_bus_arbiter: RTL

SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

---
 rtl/sys_bus_arb_pkg.sv | 18 +
 rtl/arb_sat_counter.sv | 24 ++
 rtl/sys_bus_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sys_bus_arb_pkg.sv
// Shared types and constants for the system bus arbiter.
// Holds the bus owner encoding, bus widths and fairness defaults.
package sys_bus_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam int BURST_MAX_DEF  = 8;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    ACC  = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), inc, clr, cnt (holds at MAX).
module arb_sat_counter #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != W'(MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master arbiter (core, GEMM) for a single system bus.
// Ports: core_* and acc_* requesters, bus_* slave side, clk/rst.
module sys_bus_arbiter
  import sys_bus_arb_pkg::*;
#(
  parameter int BURST_MAX  = BURST_MAX_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_en,
  input  logic              core_rdwr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic [MASK_W-1:0] core_mask,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_stall,
  input  logic              acc_req,
  input  logic              acc_rdwr,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wr_data,
  input  logic [MASK_W-1:0] acc_mask,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_rd_data,
  output logic              acc_rvalid,
  output logic              bus_en,
  output logic              bus_rdwr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic [MASK_W-1:0] bus_mask,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_ready
);

  localparam int BW = $clog2(BURST_MAX);
  localparam int SW = $clog2(STARVE_MAX + 1);

  owner_t         owner;
  owner_t         nxt;
  logic [BW-1:0]  burst_cnt;
  logic [SW-1:0]  starve_cnt;
  logic           core_win;
  logic           burst_full;
  logic           new_grant;
  logic           core_grant;
  logic           acc_grant;

  // A starved GEMM pre-empts the core only from IDLE.
  assign core_win   = core_en &&
                      !(acc_req && starve_cnt == SW'(STARVE_MAX));
  assign burst_full = burst_cnt == BW'(BURST_MAX - 1);

  always_comb begin
    nxt = owner;
    unique case (owner)
      IDLE: begin
        if (core_win)     nxt = CORE;
        else if (acc_req) nxt = ACC;
      end
      CORE: begin
        if (bus_ready) begin
          if (acc_req)      nxt = ACC;
          else if (core_en) nxt = CORE;
          else              nxt = IDLE;
        end
      end
      ACC: begin
        if (bus_ready) begin
          if (core_en && burst_full) nxt = CORE;
          else if (acc_req)          nxt = ACC;
          else if (core_en)          nxt = CORE;
          else                       nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner <= IDLE;
    else     owner <= nxt;
  end

  // A grant is a fresh beat starting: from IDLE or after completion.
  assign new_grant  = (owner == IDLE) || bus_ready;
  assign core_grant = new_grant && nxt == CORE;
  assign acc_grant  = new_grant && nxt == ACC;

  arb_sat_counter #(
    .MAX (BURST_MAX - 1),
    .W   (BW)
  ) u_burst (
    .clk (clk),
    .rst (rst),
    .inc (owner == ACC && bus_ready),
    .clr (owner != ACC),
    .cnt (burst_cnt)
  );

  arb_sat_counter #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (core_grant && acc_req),
    .clr (acc_grant),
    .cnt (starve_cnt)
  );

  always_comb begin
    bus_en       = 1'b0;
    bus_rdwr     = 1'b0;
    bus_addr     = '0;
    bus_wr_data  = '0;
    bus_mask     = '0;
    core_rd_data = '0;
    core_stall   = 1'b0;
    acc_gnt      = 1'b0;
    acc_rd_data  = '0;
    acc_rvalid   = 1'b0;
    unique case (owner)
      IDLE: begin
        core_stall = core_en;
      end
      CORE: begin
        bus_en       = 1'b1;
        bus_rdwr     = core_rdwr;
        bus_addr     = core_addr;
        bus_wr_data  = core_wr_data;
        bus_mask     = core_mask;
        core_stall   = !bus_ready;
        core_rd_data = bus_rd_data;
      end
      ACC: begin
        bus_en      = 1'b1;
        bus_rdwr    = acc_rdwr;
        bus_addr    = acc_addr;
        bus_wr_data = acc_wr_data;
        bus_mask    = acc_mask;
        acc_gnt     = 1'b1;
        acc_rvalid  = bus_ready && !acc_rdwr;
        acc_rd_data = bus_rd_data;
        core_stall  = core_en;
      end
      default: ;
    endcase
  end

endmodule
